// File: rtl/fifo_wr_arbiter_if.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter_if
//
// Bundles the producer request bus and the FIFO write port that meet at the
// round-robin write arbiter.
//
//   slave  modport : the arbiter (samples req/req_data/full,
//                    drives gnt/write_en/write_data)
//   master modport : the surroundings (producers plus the FIFO full flag)
//
// Signals
//   req         NUM_REQ              per-producer request, held until granted
//   req_data    NUM_REQ*DATA_WIDTH   producer i data in [i*DATA_WIDTH +: DATA_WIDTH]
//   gnt         NUM_REQ              one-hot accept pulse back to the producers
//   full        1                    FIFO full flag
//   write_en    1                    FIFO write strobe
//   write_data  DATA_WIDTH           FIFO write data
// -----------------------------------------------------------------------------
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 4
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            gnt;
  logic                          full;
  logic                          write_en;
  logic [DATA_WIDTH-1:0]         write_data;

  modport master (
    output req, req_data, full,
    input  gnt, write_en, write_data
  );

  modport slave (
    input  req, req_data, full,
    output gnt, write_en, write_data
  );
endinterface : fifo_wr_arbiter_if

// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Round-robin arbiter sharing the single write port of a FIFO between NUM_REQ
// producers. Each cycle one requesting producer may be accepted; its word is
// captured into a one-entry holding register, and that register drives the
// FIFO write port while honouring the FIFO full flag. A drain and a new
// accept can happen on the same edge, so a stream sustains one write per
// cycle while the FIFO is not full.
//
// Parameters
//   NUM_REQ     number of producers (2..8)
//   DATA_WIDTH  data width, must match the FIFO
//
// Ports
//   clk        in   single clock, all state on its rising edge
//   rstN       in   asynchronous active-low reset
//   bus        --   fifo_wr_arbiter_if.slave (req, req_data, gnt, full,
//                   write_en, write_data)
//   grant_cnt  out  NUM_REQ*8 per-producer saturating grant counters,
//                   counter i on [i*8 +: 8]
//
// Build option
//   FIFO_ARB_CNT_EN  when defined, builds one 8-bit saturating grant counter
//                    per producer; otherwise grant_cnt is tied to zero.
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rstN,
  fifo_wr_arbiter_if.slave       bus,
  output logic [NUM_REQ*8-1:0]   grant_cnt
);

  localparam int PTR_W = $clog2(NUM_REQ);

  typedef logic [PTR_W-1:0]      ptr_t;
  typedef logic [DATA_WIDTH-1:0] word_t;

  // Advance a producer index by one, wrapping at NUM_REQ-1 back to 0.
  function automatic ptr_t next_idx(input ptr_t p);
    return (p == ptr_t'(NUM_REQ - 1)) ? '0 : p + 1'b1;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic  hold_vld;   // holding register contains a word not yet written
  word_t hold_data;  // the word presented to the FIFO
  ptr_t  rr_ptr;     // highest-priority producer for the next accept

  // ---------------------------------------------------------------------------
  // Combinational arbitration
  // ---------------------------------------------------------------------------
  word_t              req_word [NUM_REQ];
  logic               can_accept;
  logic               found;
  logic               accept;
  ptr_t               winner;
  ptr_t               search_idx;
  logic [NUM_REQ-1:0] gnt_c;

  // Unpack the flat producer data bus into one word per producer.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_word[i] = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // The register can take a new word when it is empty or is being written to
  // the FIFO in this very cycle.
  assign can_accept = ~hold_vld | ~bus.full;

  // Rotating priority search: start at rr_ptr, walk upward with wrap, and
  // stop at the first requester.
  // NOTE: every variable assigned in this block gets a value before the loop,
  // so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    found      = 1'b0;
    winner     = rr_ptr;
    search_idx = rr_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && bus.req[search_idx]) begin
        found  = 1'b1;
        winner = search_idx;
      end
      search_idx = next_idx(search_idx);
    end
  end

  // Grants are qualified with rstN so that a producer holding its request
  // through reset never sees an accept that the held state will not honour.
  assign accept = found & can_accept & rstN;

  always_comb begin
    gnt_c = '0;
    if (accept) begin
      gnt_c[winner] = 1'b1;
    end
  end

  assign bus.gnt        = gnt_c;
  assign bus.write_en   = hold_vld & ~bus.full;
  assign bus.write_data = hold_data;

  // ---------------------------------------------------------------------------
  // Holding register and round-robin pointer
  // ---------------------------------------------------------------------------
  // An accept both drains the old word (if any) and loads the new one on the
  // same edge, so hold_vld simply stays set. Without an accept, a completed
  // write empties the register. When neither happens all state holds, and
  // rr_ptr moves only on an accept.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its inputs regardless of statement order.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      hold_vld  <= 1'b0;
      hold_data <= '0;
      rr_ptr    <= '0;
    end else if (accept) begin
      hold_vld  <= 1'b1;
      hold_data <= req_word[winner];
      rr_ptr    <= next_idx(winner);
    end else if (bus.write_en) begin
      hold_vld  <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional per-producer grant counters
  // ---------------------------------------------------------------------------
`ifdef FIFO_ARB_CNT_EN
  logic [7:0] cnt_q [NUM_REQ];

  // Counters saturate at 255 rather than wrapping, so a long-running
  // producer never appears to have been starved.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (gnt_c[i] && (cnt_q[i] != 8'hFF)) begin
          cnt_q[i] <= cnt_q[i] + 8'd1;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_cnt[i*8 +: 8] = cnt_q[i];
    end
  end
`else
  assign grant_cnt = '0;
`endif

  // ---------------------------------------------------------------------------
  // Protocol properties
  // ---------------------------------------------------------------------------
  gnt_onehot_a : assert property (@(posedge clk) disable iff (!rstN)
    $onehot0(bus.gnt));

  gnt_needs_req_a : assert property (@(posedge clk) disable iff (!rstN)
    ((bus.gnt & ~bus.req) == '0));

endmodule : fifo_wr_arbiter

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//
// Directed bench for fifo_wr_arbiter. Stimulus drives requests and the FIFO
// full flag shortly after each rising edge and checks grants on the falling
// edge. Each accepted word is pushed into an expected-write queue; a separate
// monitor pops that queue whenever write_en is seen high and compares the
// written data, so the write stream is checked in order and independently of
// the stimulus.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

  localparam int NR = 4;
  localparam int DW = 4;

  logic              clk = 1'b0;
  logic              rstN;
  logic [NR*8-1:0]   grant_cnt;

  fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rstN      (rstN),
    .bus       (bus.slave),
    .grant_cnt (grant_cnt)
  );

  always #5 clk = ~clk;

  int              tests = 0;
  int              fails = 0;
  logic [DW-1:0]   exp_wr [$];
  logic [DW-1:0]   mon_exp;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_data(input int idx, input logic [DW-1:0] d);
    bus.req_data[idx*DW +: DW] = d;
  endtask

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rstN = 1'b0;
    exp_wr.delete();
    next_cycle();
    rstN = 1'b1;
  endtask

  // Write monitor: every observed FIFO write must match the oldest accept.
  always @(negedge clk) begin
    if (rstN === 1'b1 && bus.write_en === 1'b1) begin
      if (exp_wr.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: write_data=0x%0h with nothing pending at %0t",
                 bus.write_data, $time);
      end else begin
        mon_exp = exp_wr.pop_front();
        check("write_data", 32'(bus.write_data), 32'(mon_exp));
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_cnt;

    rstN         = 1'b0;
    bus.req      = '0;
    bus.full     = 1'b0;
    bus.req_data = '0;

    // ---------------- reset state ----------------
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_write_en",   32'(bus.write_en),   32'd0);
    check("rst_write_data", 32'(bus.write_data), 32'd0);
    check("rst_gnt",        32'(bus.gnt),        32'd0);
    check("rst_grant_cnt",  grant_cnt,           32'd0);
    next_cycle();
    rstN = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("idle_write_en",  32'(bus.write_en), 32'd0);
      check("idle_gnt",       32'(bus.gnt),      32'd0);
      check("idle_grant_cnt", grant_cnt,         32'd0);
      next_cycle();
    end

    // ---------------- single producer ----------------
    set_data(2, 4'hA);
    bus.req = 4'b0100;
    @(negedge clk);
    check("single_gnt", 32'(bus.gnt), 32'b0100);
    exp_wr.push_back(4'hA);
    next_cycle();
    // rr_ptr is now 3: producers 0 and 3 both request, 3 must win.
    bus.req = 4'b1001;
    set_data(0, 4'h1);
    set_data(3, 4'h3);
    @(negedge clk);
    check("single_write_en", 32'(bus.write_en), 32'd1);
    check("ptr3_gnt",        32'(bus.gnt),      32'b1000);
    exp_wr.push_back(4'h3);
    next_cycle();
    bus.req = 4'b0001;
    @(negedge clk);
    check("wrap_gnt",      32'(bus.gnt),      32'b0001);
    check("wrap_write_en", 32'(bus.write_en), 32'd1);
    exp_wr.push_back(4'h1);
    next_cycle();
    bus.req = 4'b0000;
    @(negedge clk);
    check("drain_write_en", 32'(bus.write_en), 32'd1);
    check("drain_gnt",      32'(bus.gnt),      32'd0);
    next_cycle();
    @(negedge clk);
    check("empty_write_en", 32'(bus.write_en), 32'd0);
    next_cycle();

    // ---------------- all requesting ----------------
    pulse_reset();
    for (int i = 0; i < NR; i++) set_data(i, 4'(i));
    bus.req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("rr_gnt", 32'(bus.gnt), 32'(1 << (k % NR)));
      if (k > 0) check("rr_no_bubble", 32'(bus.write_en), 32'd1);
      exp_wr.push_back(4'(k % NR));
      next_cycle();
    end
    bus.req = 4'b0000;
    @(negedge clk);
    check("rr_last_write_en", 32'(bus.write_en), 32'd1);
    next_cycle();

    // ---------------- backpressure (rr_ptr is 0) ----------------
    set_data(1, 4'h5);
    bus.req = 4'b0010;
    @(negedge clk);
    check("bp_load_gnt", 32'(bus.gnt), 32'b0010);
    exp_wr.push_back(4'h5);
    next_cycle();
    set_data(1, 4'h6);
    bus.full = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("bp_write_en", 32'(bus.write_en), 32'd0);
      check("bp_gnt",      32'(bus.gnt),      32'd0);
      next_cycle();
    end
    bus.full = 1'b0;
    @(negedge clk);
    check("bp_resume_write_en", 32'(bus.write_en), 32'd1);
    check("bp_resume_gnt",      32'(bus.gnt),      32'b0010);
    exp_wr.push_back(4'h6);
    next_cycle();
    bus.req = 4'b0000;
    @(negedge clk);
    check("bp_drain_write_en", 32'(bus.write_en), 32'd1);
    next_cycle();

    // ---------------- mid-operation reset ----------------
    set_data(1, 4'h7);
    bus.req = 4'b0010;
    @(negedge clk);
    check("mid_load_gnt", 32'(bus.gnt), 32'b0010);
    exp_wr.push_back(4'h7);
    next_cycle();
    bus.req  = 4'b0000;
    bus.full = 1'b1;
    @(negedge clk);
    check("mid_hold_write_en", 32'(bus.write_en), 32'd0);
    next_cycle();
    for (int i = 0; i < NR; i++) set_data(i, 4'(i));
    bus.req = 4'b1111;
    #1;
    rstN = 1'b0;
    exp_wr.delete();     // the held 0x7 must never appear
    bus.full = 1'b0;
    #1;
    check("mid_rst_write_en", 32'(bus.write_en), 32'd0);
    check("mid_rst_gnt",      32'(bus.gnt),      32'd0);
    next_cycle();
    rstN = 1'b1;
    for (int k = 0; k < NR; k++) begin
      @(negedge clk);
      check("post_rst_gnt", 32'(bus.gnt), 32'(1 << k));
      exp_wr.push_back(4'(k));
      next_cycle();
    end
    bus.req = 4'b0000;
    repeat (2) next_cycle();

    // ---------------- grant counters ----------------
    pulse_reset();
    set_data(0, 4'h9);
    bus.req = 4'b0001;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      exp_wr.push_back(4'h9);
      next_cycle();
    end
    bus.req = 4'b0000;
    @(negedge clk);
`ifdef FIFO_ARB_CNT_EN
    exp_cnt = {8'd0, 8'd0, 8'd0, 8'd255};
`else
    exp_cnt = 32'd0;
`endif
    check("grant_cnt", grant_cnt, exp_cnt);
    next_cycle();

    // ---------------- wrap-up ----------------
    repeat (3) next_cycle();
    check("queue_empty", 32'(exp_wr.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_fifo_wr_arbiter

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares the single write port of the 4-bit `FIFO` between `NUM_REQ` producers. Each cycle it picks one requesting producer, captures its data into a one-entry holding register, and drives the FIFO `write_en`/`write_data` from that register while honouring `full`. It sits directly in front of the FIFO, so the existing FIFO scoreboard keeps checking in-order transfer unchanged.

## Interface
- `NUM_REQ`, 4: number of producers, 2..8.
- `DATA_WIDTH`, 4: data width; must match the FIFO.
- `clk`  in  1  single clock; all logic on its rising edge.
- `rstN`  in  1  asynchronous, active-low reset.
- `req`  in  NUM_REQ  per-producer request; held with its data until granted.
- `req_data`  in  NUM_REQ*DATA_WIDTH  producer i data in bits [i*DATA_WIDTH +: DATA_WIDTH].
- `gnt`  out  NUM_REQ  one-hot accept pulse; combinational from `req`, state and `full`.
- `full`  in  1  FIFO full flag.
- `write_en`  out  1  FIFO write strobe.
- `write_data`  out  DATA_WIDTH  FIFO write data.
- `grant_cnt`  out  NUM_REQ*8  per-producer grant counters (see Configuration).

## Operation
- State: `hold_vld`, `hold_data`, round-robin pointer `rr_ptr` of $clog2(NUM_REQ) bits.
- `write_en = hold_vld & ~full`; `write_data = hold_data`. `write_data` holds its value while `write_en` is low.
- Accept condition: `can_accept = ~hold_vld | ~full`. This means the register is empty, or it drains in this same cycle.
- Arbitration: when `can_accept` is high, the winner is the first requester with `req` high, searching from index `rr_ptr` upward and wrapping at NUM_REQ-1 to 0. `gnt[winner]` is driven high for that cycle only.
- On accept:
  - `hold_data <= req_data[winner]`
  - `hold_vld <= 1`
  - `rr_ptr <= winner+1`, wrapping to 0 at NUM_REQ.
- If `write_en` is high and no request is accepted in the same cycle, `hold_vld <= 0`.
- If `can_accept` is low (holding register full and FIFO full): `gnt` = 0, and all state holds.
- `rr_ptr` changes only on accept. It does not move in idle cycles.
- A producer must not drop `req` or change its data before `gnt`. Behaviour if it does is undefined, and verification constrains this away.
- `gnt` is at most one-hot, and is never set for a producer whose `req` is low.

## Timing
- Reset values: `hold_vld`=0, `hold_data`=0, `rr_ptr`=0, `write_en`=0, `write_data`=0, `gnt`=0, `grant_cnt`=0.
- Latency: a request granted in cycle N reaches `write_en` in cycle N+1 at the earliest. If `full` is high in cycle N+1, the write is delayed until `full` drops.
- Throughput: one write per cycle while `full` is low and at least one `req` is high.
- Simultaneous drain and accept: the old `hold_data` is written and the new data is loaded on the same edge, with no bubble.
- `full` rising while `hold_vld`=1: the data is held, `write_en`=0, and no grants are issued. Writes resume in the first cycle `full` is low.
- Reset asserted mid-operation: the held word is discarded, not written. Producers keep their requests and are re-arbitrated starting from index 0.
- Fairness: with all producers requesting continuously, each producer is granted exactly once in every NUM_REQ accepts.

## Configuration
- `FIFO_ARB_CNT_EN` defined:
  - Each producer has an 8-bit grant counter, cleared by reset.
  - The counter increments on every `gnt[i]` and saturates at 255.
  - Counter i is driven on `grant_cnt[i*8 +: 8]`.
- `FIFO_ARB_CNT_EN` undefined: no counter registers are built, and `grant_cnt` is tied to 0.

## Test plan
- Reset: release `rstN` with all `req`=0 → `write_en`=0, `gnt`=0, `grant_cnt`=0 for 10 cycles.
- Single producer: `req[2]`=1 with data 0xA, `full`=0 → `gnt`=4'b0100 in cycle N. Then `write_en`=1 with `write_data`=0xA in cycle N+1, and `rr_ptr`=3.
- All requesting, data i = i, `full`=0 → `gnt` order 0,1,2,3,0,… and writes 0,1,2,3,0 on consecutive cycles with no bubbles.
- Backpressure: load 0x5, hold `full`=1 for 3 cycles with `req[1]` high → `write_en`=0 and `gnt`=0 for those 3 cycles. In the cycle `full` drops, 0x5 is written and `gnt[1]` is high in the same cycle.
- Mid-operation reset: `hold_vld`=1 holding 0x7, assert `rstN`=0 → `write_en` drops immediately, and 0x7 is never written after release.
- With `FIFO_ARB_CNT_EN`: grant producer 0 300 times → `grant_cnt[7:0]`=255, and the other counters are unchanged.
